tm1638_keyscan: RTL and testbench
=================================

// Module: tm1638_keyscan
// PURPOSE
// - Reads the TM1638 key-scan matrix (command 0x42, 4 data bytes) over the STB/CLK/DIO bus.
// - Runs beside the tm1638 display writer, which also uses this bus; bus_req/bus_gnt arbitrates between them.
// - Publishes a 32-bit raw key image for the keypad/CPU side of the LCDS board.
// PARAMETERS
// - SCAN_PERIOD  default 10000 : clken ticks from end of one scan to next bus_req (10 ms at 1 MHz)
// - WAIT_TICKS   default 2     : clken ticks, DIO released, between command byte and first read bit (TM1638 Twait >= 1 us)
// PORTS
// - clk          in   1  : single clock (cpu_clk domain)
// - rst_n        in   1  : synchronous, active-low reset
// - clken        in   1  : bus tick enable; every FSM/bit step advances only on clken=1
// - bus_req      out  1  : request for the shared TM1638 bus
// - bus_gnt      in   1  : grant from the arbiter/display writer; must stay high while bus_req=1
// - tm1638_stb   out  1  : strobe, active low
// - tm1638_clk   out  1  : serial clock, idles high
// - tm1638_dio_o out  1  : DIO drive value
// - tm1638_dio_oe out 1  : DIO output enable (1 = drive)
// - tm1638_dio_i in   1  : DIO sampled value (2-flop synchronised internally)
// - keys         out  32 : key image; byte n of the read is keys[8n+7:8n], bit order LSB-first
// - keys_valid   out  1  : 1-clk pulse when keys is updated
// - keys_changed out  1  : 1-clk pulse with keys_valid when the new image differs from the previous one
// BEHAVIOUR
// - Reset (rst_n=0 at posedge clk): state=IDLE, period counter=0, bus_req=0, stb=1, clk=1, dio_o=1, dio_oe=0,
//   keys=0, keys_valid=0, keys_changed=0. Reset mid-scan aborts at once; no partial update.
// - FSM (steps only on clken except where stated):
//   IDLE: count clken ticks to SCAN_PERIOD-1, then -> REQ (bus_req=1).
//   REQ: on bus_gnt=1 -> START. bus_gnt is checked every clk, not only on clken.
//   START: stb=0, dio_oe=1 -> CMD.
//   CMD: 16 ticks for 0x42, LSB first. Even tick: clk=0 and dio_o=bit. Odd tick: clk=1. -> WAIT.
//   WAIT: dio_oe=0, clk=1, hold WAIT_TICKS ticks -> READ.
//   READ: 64 ticks. Even tick: clk=0. Odd tick: clk=1, then shift in the synchronised dio_i at bit position n (n=0..31).
//   STOP: stb=1, clk=1 -> DONE.
//   DONE (single clk, no clken needed): keys<=shift reg, keys_valid=1, keys_changed=(shift reg != old keys).
//   bus_req=0, counter=0 -> IDLE.
// - Bus hold: bus_req stays high from REQ through STOP. Total bus hold = 1+16+WAIT_TICKS+64+1 ticks (84 at defaults).
// - Grant loss: bus_gnt=0 in any state START..STOP -> same clk: stb=1, clk=1, dio_oe=0, bus_req=0.
//   No keys update, no pulses; counter=0 -> IDLE (retry after a full period).
// - Simultaneous: if clken and grant loss land on the same clk, the abort wins.
//   keys_valid/keys_changed are never high outside DONE.
// - Sync delay: the 2-flop synchroniser adds 2 clk latency. Implementation must ensure clk period x2 < one clken tick
//   (true for 4 MHz clk / 1 MHz clken); otherwise sampling is unspecified.
// - Counter width: $clog2(SCAN_PERIOD+1); wraps only via explicit clear, never by overflow.
// CONFIGURATION
// - TM1638_KEYSCAN_DEBOUNCE_EN defined: a scan result is held as candidate. keys updates (with valid/changed pulses)
//   only when two consecutive completed scans are bit-identical and differ from keys. An aborted scan leaves the
//   candidate unchanged. A mismatched scan replaces the candidate and produces no pulse.
// - Not defined: every completed scan updates keys and pulses keys_valid. keys_changed is per the BEHAVIOUR rule.
// TESTING
// - Reset: rst_n=0 for 3 clk -> stb=1, clk=1, dio_oe=0, bus_req=0, keys=0. Hold rst_n=0 mid-READ -> same values
//   next clk, keys unchanged.
// - Basic scan (SCAN_PERIOD=20, gnt tied 1, slave model returns 0x01,0x00,0x80,0x10) ->
//   DIO shows 0,1,0,0,0,0,1,0 on clk rises; keys=32'h1080_0001; keys_valid and keys_changed each 1 clk high.
// - Repeat identical data -> second keys_valid=1 with keys_changed=0, about 20 ticks after first STOP.
// - Arbitration: hold bus_gnt=0 for 50 ticks after bus_req -> stb stays 1, no clk toggles; raise gnt ->
//   scan begins next clken.
// - Grant loss: drop bus_gnt at READ bit 10 -> stb=1, dio_oe=0 same clk; keys unchanged; no pulse; bus_req=0;
//   next request after SCAN_PERIOD ticks.
// - Debounce EN: scans return A,B,B -> keys updates to B only after the third scan. Without the macro ->
//   keys=A, then B, then B.

Source files
------------

// File: rtl/tm1638_keyscan_if.sv
// Signal bundle for the TM1638 key-scan reader: bus arbitration, serial pins and the published key image.
interface tm1638_keyscan_if;
  logic        bus_req;
  logic        bus_gnt;
  logic        tm1638_stb;
  logic        tm1638_clk;
  logic        tm1638_dio_o;
  logic        tm1638_dio_oe;
  logic        tm1638_dio_i;
  logic [31:0] keys;
  logic        keys_valid;
  logic        keys_changed;

  modport master (
    output bus_req, tm1638_stb, tm1638_clk, tm1638_dio_o, tm1638_dio_oe,
    output keys, keys_valid, keys_changed,
    input  bus_gnt, tm1638_dio_i
  );

  modport slave (
    input  bus_req, tm1638_stb, tm1638_clk, tm1638_dio_o, tm1638_dio_oe,
    input  keys, keys_valid, keys_changed,
    output bus_gnt, tm1638_dio_i
  );
endinterface

// File: rtl/tm1638_keyscan.sv
// TM1638 key-matrix reader (command 0x42 + 4 data bytes) sharing the display bus through bus_req/bus_gnt.
// Define TM1638_KEYSCAN_DEBOUNCE_EN to publish a new image only after two identical consecutive scans.
module tm1638_keyscan #(
  parameter int SCAN_PERIOD = 10000,
  parameter int WAIT_TICKS  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clken,
  tm1638_keyscan_if.master bus
);
  localparam int PW = $clog2(SCAN_PERIOD + 1);
  localparam int SW = ($clog2(WAIT_TICKS + 1) > 6) ? $clog2(WAIT_TICKS + 1) : 6;
  localparam logic [7:0] CMD_BYTE = 8'h42;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_START, S_CMD, S_WAIT, S_READ, S_STOP, S_DONE
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] pcnt, pcnt_n;
  logic [SW-1:0] step, step_n;
  logic          stb_q, stb_n;
  logic          sclk_q, sclk_n;
  logic          dio_q, dio_n;
  logic          oe_q, oe_n;
  logic [31:0]   shift, shift_n;
  logic [31:0]   keys_q, keys_n;
  logic          valid_q, valid_n;
  logic          chg_q, chg_n;
  logic          dio_s1, dio_s2;
  logic          active, abort;
`ifdef TM1638_KEYSCAN_DEBOUNCE_EN
  logic [31:0]   cand, cand_n;
  logic          cand_vld, cand_vld_n;
`endif

  // Losing the grant must release the pins in the same cycle, so the pin drivers are gated combinationally.
  assign active = state inside {S_START, S_CMD, S_WAIT, S_READ, S_STOP};
  assign abort  = active && !bus.bus_gnt;

  assign bus.bus_req       = (state == S_REQ) || (active && bus.bus_gnt);
  assign bus.tm1638_stb    = abort | stb_q;
  assign bus.tm1638_clk    = abort | sclk_q;
  assign bus.tm1638_dio_o  = abort | dio_q;
  assign bus.tm1638_dio_oe = ~abort & oe_q;
  assign bus.keys          = keys_q;
  assign bus.keys_valid    = valid_q;
  assign bus.keys_changed  = chg_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pcnt     <= '0;
      step     <= '0;
      stb_q    <= 1'b1;
      sclk_q   <= 1'b1;
      dio_q    <= 1'b1;
      oe_q     <= 1'b0;
      shift    <= '0;
      keys_q   <= '0;
      valid_q  <= 1'b0;
      chg_q    <= 1'b0;
      dio_s1   <= 1'b1;
      dio_s2   <= 1'b1;
`ifdef TM1638_KEYSCAN_DEBOUNCE_EN
      cand     <= '0;
      cand_vld <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      pcnt     <= pcnt_n;
      step     <= step_n;
      stb_q    <= stb_n;
      sclk_q   <= sclk_n;
      dio_q    <= dio_n;
      oe_q     <= oe_n;
      shift    <= shift_n;
      keys_q   <= keys_n;
      valid_q  <= valid_n;
      chg_q    <= chg_n;
      dio_s1   <= bus.tm1638_dio_i;
      dio_s2   <= dio_s1;
`ifdef TM1638_KEYSCAN_DEBOUNCE_EN
      cand     <= cand_n;
      cand_vld <= cand_vld_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    pcnt_n     = pcnt;
    step_n     = step;
    stb_n      = stb_q;
    sclk_n     = sclk_q;
    dio_n      = dio_q;
    oe_n       = oe_q;
    shift_n    = shift;
    keys_n     = keys_q;
    valid_n    = 1'b0;
    chg_n      = 1'b0;
`ifdef TM1638_KEYSCAN_DEBOUNCE_EN
    cand_n     = cand;
    cand_vld_n = cand_vld;
`endif
    if (abort) begin
      state_n = S_IDLE;
      pcnt_n  = '0;
      step_n  = '0;
      stb_n   = 1'b1;
      sclk_n  = 1'b1;
      dio_n   = 1'b1;
      oe_n    = 1'b0;
    end else begin
      case (state)
        S_IDLE: if (clken) begin
          if (pcnt == PW'(SCAN_PERIOD - 1)) begin
            state_n = S_REQ;
            pcnt_n  = '0;
          end else begin
            pcnt_n = pcnt + 1'b1;
          end
        end
        // Grant is honoured on any cycle so the display writer can hand over without waiting for a tick.
        S_REQ: if (bus.bus_gnt) state_n = S_START;
        S_START: if (clken) begin
          stb_n   = 1'b0;
          oe_n    = 1'b1;
          step_n  = '0;
          shift_n = '0;
          state_n = S_CMD;
        end
        S_CMD: if (clken) begin
          if (!step[0]) begin
            sclk_n = 1'b0;
            dio_n  = CMD_BYTE[step[3:1]];
          end else begin
            sclk_n = 1'b1;
          end
          if (step == SW'(15)) begin
            step_n  = '0;
            state_n = S_WAIT;
          end else begin
            step_n = step + 1'b1;
          end
        end
        S_WAIT: if (clken) begin
          oe_n   = 1'b0;
          sclk_n = 1'b1;
          dio_n  = 1'b1;
          if (step == SW'(WAIT_TICKS - 1)) begin
            step_n  = '0;
            state_n = S_READ;
          end else begin
            step_n = step + 1'b1;
          end
        end
        // The slave changes DIO on the falling edge; sampling on the rising tick leaves the synchroniser time to settle.
        S_READ: if (clken) begin
          if (!step[0]) begin
            sclk_n = 1'b0;
          end else begin
            sclk_n                = 1'b1;
            shift_n[step[5:1]] = dio_s2;
          end
          if (step == SW'(63)) begin
            step_n  = '0;
            state_n = S_STOP;
          end else begin
            step_n = step + 1'b1;
          end
        end
        S_STOP: if (clken) begin
          stb_n   = 1'b1;
          sclk_n  = 1'b1;
          state_n = S_DONE;
        end
        S_DONE: begin
          state_n = S_IDLE;
          pcnt_n  = '0;
`ifdef TM1638_KEYSCAN_DEBOUNCE_EN
          cand_n     = shift;
          cand_vld_n = 1'b1;
          if (cand_vld && (shift == cand) && (shift != keys_q)) begin
            keys_n  = shift;
            valid_n = 1'b1;
            chg_n   = 1'b1;
          end
`else
          keys_n  = shift;
          valid_n = 1'b1;
          chg_n   = (shift != keys_q);
`endif
        end
        default: state_n = S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tm1638_keyscan.sv
// Directed bench for tm1638_keyscan: TM1638 slave model, expected key images queued per scan and checked on keys_valid.
module tb_tm1638_keyscan;
  localparam int SP = 20;
  localparam int WT = 2;

  typedef struct packed {
    logic [31:0] keys;
    logic        changed;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clken = 1'b0;

  tm1638_keyscan_if ifc ();

  tm1638_keyscan #(.SCAN_PERIOD(SP), .WAIT_TICKS(WT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clken (clken),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  exp_t        exp_q[$];
  logic [31:0] slave_data = '0;
  logic [31:0] m_keys = '0;
  logic [31:0] m_cand = '0;
  logic        m_cand_vld = 1'b0;
  logic [7:0]  cmd_seen = '0;
  int          cmd_bits = 0, rd_bits = 0, clk_edges = 0, stb_falls = 0, valid_cnt = 0;
  int          gap = 0, last_gap = -1, hold = 0, last_hold = -1;
  logic        prev_req = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference behaviour of one completed scan returning d.
  function automatic void expect_scan(input logic [31:0] d);
    exp_t e;
`ifdef TM1638_KEYSCAN_DEBOUNCE_EN
    if (m_cand_vld && d == m_cand && d != m_keys) begin
      e.keys = d; e.changed = 1'b1;
      exp_q.push_back(e);
      m_keys = d;
    end
    m_cand = d; m_cand_vld = 1'b1;
`else
    e.keys = d; e.changed = (d != m_keys);
    exp_q.push_back(e);
    m_keys = d;
`endif
  endfunction

  // clken: one cycle in four, changed away from the active edge.
  initial begin : clken_gen
    int div;
    div = 0;
    forever begin
      @(posedge clk);
      #2;
      div = (div + 1) % 4;
      clken = (div == 0);
    end
  end

  // TM1638 slave: latches the command on clk rises, drives read bits on clk falls.
  initial begin : slave
    logic pc, ps;
    ifc.tm1638_dio_i = 1'b1;
    pc = 1'b1; ps = 1'b1;
    forever begin
      @(ifc.tm1638_stb or ifc.tm1638_clk);
      if (ifc.tm1638_clk !== pc) clk_edges++;
      if (ps === 1'b1 && ifc.tm1638_stb === 1'b0) begin
        stb_falls++;
        cmd_seen = '0;
      end
      if (ifc.tm1638_stb !== 1'b0) begin
        cmd_bits = 0; rd_bits = 0; ifc.tm1638_dio_i = 1'b1;
      end else if (ifc.tm1638_clk === 1'b1 && pc === 1'b0) begin
        if (cmd_bits < 8) begin
          cmd_seen[cmd_bits[2:0]] = ifc.tm1638_dio_o;
          cmd_bits++;
        end
      end else if (ifc.tm1638_clk === 1'b0 && pc === 1'b1 && cmd_bits == 8 && rd_bits < 32) begin
        ifc.tm1638_dio_i = slave_data[rd_bits[4:0]];
        rd_bits++;
      end
      pc = ifc.tm1638_clk;
      ps = ifc.tm1638_stb;
    end
  end

  // Bus-hold / idle-gap tick counters and the scoreboard pop on keys_valid.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n !== 1'b1) begin
        gap = 0; hold = 0; prev_req = 1'b0;
      end else begin
        if (ifc.bus_req === 1'b1 && !prev_req) begin last_gap = gap; gap = 0; hold = 0; end
        if (ifc.bus_req === 1'b0 && prev_req) last_hold = hold;
        if (clken) begin
          if (ifc.bus_req === 1'b1) hold++;
          else gap++;
        end
        prev_req = (ifc.bus_req === 1'b1);
      end
      if (ifc.keys_valid === 1'b1) begin
        valid_cnt++;
        if (exp_q.size() == 0) chk("unexpected_valid", 32'(ifc.keys_valid), 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("keys", ifc.keys, e.keys);
          chk("keys_changed", 32'(ifc.keys_changed), 32'(e.changed));
        end
      end else if (ifc.keys_changed !== 1'b0 && rst_n === 1'b1) begin
        chk("changed_without_valid", 32'(ifc.keys_changed), 32'd0);
      end
    end
  end

  task automatic tick();
    do @(negedge clk); while (clken !== 1'b1);
    @(negedge clk);
  endtask

  task automatic wait_req(input logic lvl, input string tag);
    int n;
    n = 0;
    while (ifc.bus_req !== lvl && n < 3000) begin @(negedge clk); n++; end
    if (ifc.bus_req !== lvl) chk(tag, 32'(ifc.bus_req), 32'(lvl));
  endtask

  task automatic wait_rd(input int bits, input string tag);
    int n;
    n = 0;
    while (rd_bits < bits && n < 3000) begin @(negedge clk); n++; end
    if (rd_bits < bits) chk(tag, rd_bits, bits);
  endtask

  task automatic scan(input logic [31:0] d);
    slave_data = d;
    expect_scan(d);
    wait_req(1'b1, "scan_req_timeout");
    wait_req(1'b0, "scan_end_timeout");
    repeat (2) @(negedge clk);
    chk("cmd_byte", {24'h0, cmd_seen}, 32'h42);
  endtask

  initial begin : main
    int vc, ec, sc;
    ifc.bus_gnt = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_stb", 32'(ifc.tm1638_stb), 32'd1);
    chk("rst_clk", 32'(ifc.tm1638_clk), 32'd1);
    chk("rst_dio_o", 32'(ifc.tm1638_dio_o), 32'd1);
    chk("rst_dio_oe", 32'(ifc.tm1638_dio_oe), 32'd0);
    chk("rst_bus_req", 32'(ifc.bus_req), 32'd0);
    chk("rst_keys", ifc.keys, 32'h0);
    chk("rst_valid", 32'(ifc.keys_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic scan, then identical repeat
    scan(32'h1080_0001);
    chk("first_gap", last_gap, SP);
    chk("bus_hold_ticks", last_hold, 1 + 16 + WT + 64 + 1);
    scan(32'h1080_0001);
    chk("repeat_gap", last_gap, SP);

    // arbitration: grant withheld for 50 ticks after the request
    ifc.bus_gnt = 1'b0;
    wait_req(1'b1, "arb_req_timeout");
    ec = clk_edges; sc = stb_falls;
    repeat (50) tick();
    chk("arb_stb_idle", 32'(ifc.tm1638_stb), 32'd1);
    chk("arb_clk_edges", clk_edges, ec);
    chk("arb_stb_falls", stb_falls, sc);
    slave_data = 32'hA5C3_0F96;
    expect_scan(slave_data);
    ifc.bus_gnt = 1'b1;
    tick();
    #1;
    chk("arb_start_stb", 32'(ifc.tm1638_stb), 32'd0);
    wait_req(1'b0, "arb_end_timeout");
    repeat (2) @(negedge clk);
    chk("arb_cmd_byte", {24'h0, cmd_seen}, 32'h42);

    // grant loss at read bit 10
    slave_data = 32'h0BAD_F00D;
    vc = valid_cnt;
    wait_req(1'b1, "gl_req_timeout");
    wait_rd(10, "gl_rd_timeout");
    ifc.bus_gnt = 1'b0;
    #1;
    chk("gl_stb", 32'(ifc.tm1638_stb), 32'd1);
    chk("gl_clk", 32'(ifc.tm1638_clk), 32'd1);
    chk("gl_dio_oe", 32'(ifc.tm1638_dio_oe), 32'd0);
    chk("gl_bus_req", 32'(ifc.bus_req), 32'd0);
    repeat (2) @(negedge clk);
    ifc.bus_gnt = 1'b1;
    chk("gl_keys_kept", ifc.keys, m_keys);
    expect_scan(slave_data);
    wait_req(1'b1, "gl_retry_timeout");
    chk("gl_retry_gap", last_gap, SP);
    chk("gl_no_pulse", valid_cnt, vc);
    wait_req(1'b0, "gl_end_timeout");
    repeat (2) @(negedge clk);

    // reset held in the middle of a read
    slave_data = 32'h7E57_1234;
    vc = valid_cnt;
    wait_req(1'b1, "mr_req_timeout");
    wait_rd(5, "mr_rd_timeout");
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("mr_stb", 32'(ifc.tm1638_stb), 32'd1);
    chk("mr_clk", 32'(ifc.tm1638_clk), 32'd1);
    chk("mr_dio_oe", 32'(ifc.tm1638_dio_oe), 32'd0);
    chk("mr_bus_req", 32'(ifc.bus_req), 32'd0);
    chk("mr_no_pulse", valid_cnt, vc);
    m_keys = '0; m_cand_vld = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    scan(32'h7E57_1234);

    // A, B, B sequence
    scan(32'h0000_00FF);
    scan(32'h8000_0100);
    scan(32'h8000_0100);
    chk("final_keys", ifc.keys, m_keys);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
